y86_dmem_responder: RTL and testbench
=====================================

Name: y86_dmem_responder

Overview:
- Data-memory responder for the Y86 core: the slave end of the CPU's data-memory access interface.
- Accepts one read or write request at a time over a valid/ready handshake.
- Models a configurable access latency and returns data plus an address-error flag. The core folds that flag into `stat` as dmem_error.
- Sits between the memory stage and a byte-addressed storage array; replaces the zero-latency memory model.

Parameters:
- DATA_WID, 64, access width in bits; equals `DATA_WID from header/head.v; multiple of 8.
- ADDR_WID, 64, request address width.
- MEM_BYTES, 1024, storage size in bytes; power of two.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WID  byte address of the access.
- req_wdata  input  DATA_WID  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_WID  read data; 0 for writes and errors.
- rsp_error  output  1  address out of range.
- busy  output  1  a request is outstanding (not IDLE).

Behaviour:
Reset
- RST asserted drives the FSM to IDLE immediately.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0; latency counter=0.
- Storage contents are NOT cleared by reset.
- Reset mid-operation (WAIT or RESP) discards the request. A pending write that has not committed never commits.

FSM: IDLE, WAIT, RESP.

IDLE
- req_ready=1.
- On an edge with req_valid=1:
  - latch req_write, req_addr, req_wdata;
  - load counter with LATENCY-1;
  - go to WAIT.

WAIT
- req_ready=0, busy=1.
- Counter decrements each edge.
- On the edge where counter==0, perform the access and go to RESP.
- Net effect: rsp_valid rises exactly LATENCY edges after the accept edge. With LATENCY=1, WAIT lasts one cycle.

Access, evaluated at the WAIT-exit edge
- Range check: error = (addr + DATA_WID/8 - 1) >= MEM_BYTES. Compute the sum at ADDR_WID+1 bits so wrap-around past 2^ADDR_WID also counts as an error.
- Byte order: little-endian; byte addr holds bits [7:0]. Unaligned addresses are legal.
- Read, no error: rsp_rdata = assembled bytes.
- Write, no error: all DATA_WID/8 bytes are committed; rsp_rdata = 0.
- Any error: storage is unchanged, rsp_rdata = 0, rsp_error = 1.

RESP
- rsp_valid=1; rsp_rdata and rsp_error stay stable until the handshake.
- On an edge with rsp_ready=1: go to IDLE and clear rsp_valid, rsp_rdata and rsp_error.
- req_ready becomes 1 the cycle after the response handshake. Minimum request spacing is therefore LATENCY+2 cycles.
- rsp_ready is ignored outside RESP.
- Request inputs are ignored outside IDLE: no queueing, no overwrite of the latched request.

Same-address ordering
- A read issued after a write completes returns the written data. This follows from single-outstanding operation.

Decomposition:
- Shared package / header/head.v:
  - `DATA_WID;
  - FSM state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - `MEM_ERR stat code.
- One natural sub-module: dmem_byte_array.
  - Synchronous byte-addressed storage with a DATA_WID/8-byte-wide read and write port at base address.
  - No reset.
  - Holds the storage and the byte assembly; the top keeps the FSM, counter and range check.

Test Plan:
1. Reset mid-WAIT
   - Stimulus: write addr 0x10 data 0x1122334455667788; assert RST one cycle after acceptance; deassert; read 0x10.
   - Required: read returns the pre-reset contents, not 0x1122334455667788; rsp_error=0.
2. Write then read, LATENCY=2
   - Stimulus: write 0x0123456789ABCDEF to addr 0x20; then read 0x20.
   - Required: rsp_valid exactly 2 edges after each accept; read returns 0x0123456789ABCDEF; byte read of 0x20 region shows byte 0x20 = 0xEF.
3. Unaligned access and boundary
   - Stimulus: write to 0x3F9 (MEM_BYTES=1024).
   - Required: rsp_error=1, storage unchanged.
   - Stimulus: read 0x3F8.
   - Required: rsp_error=0, data returned.
4. Wrap-around
   - Stimulus: read addr 0xFFFFFFFFFFFFFFFC.
   - Required: rsp_error=1, rsp_rdata=0.
5. Response backpressure
   - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
   - Required: rsp_valid, rsp_rdata and rsp_error stable and req_ready=0 throughout; req_ready=1 one cycle after the rsp_ready handshake.
6. LATENCY=1 back-to-back
   - Stimulus: keep req_valid high continuously with rsp_ready=1.
   - Required: accepts occur every 3 cycles; no request is lost or duplicated; busy is high between each accept and its response handshake.

Source files
------------

// File: rtl/y86_dmem_responder_pkg.sv
// Shared definitions for the Y86 data-memory responder: access width,
// FSM state encodings and the stat code the core raises on dmem_error.
package y86_dmem_responder_pkg;

  localparam int DMEM_DATA_WID = 64;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  // Y86 status code reported when a data access falls outside memory
  localparam logic [2:0] STAT_MEM_ERR = 3'd3;

  function automatic logic [3:0] latency_preload(input int latency);
    return 4'(latency - 1);
  endfunction

endpackage

// File: rtl/y86_dmem_responder_byte_array.sv
// Byte-addressed storage with a word-wide little-endian port at an arbitrary
// base address; synchronous write, combinational read assembly, no reset.
module dmem_byte_array #(
  parameter int DATA_WID  = 64,
  parameter int MEM_BYTES = 1024
) (
  input  logic                         CLK,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_BYTES)-1:0] base,
  input  logic [DATA_WID-1:0]          wdata,
  output logic [DATA_WID-1:0]          rdata
);

  localparam int NBYTES  = DATA_WID / 8;
  localparam int IDX_WID = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        mem[base + IDX_WID'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Byte at the base address lands in the least significant lane
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NBYTES; i++) begin
      rdata[8*i +: 8] = mem[base + IDX_WID'(i)];
    end
  end

endmodule

// File: rtl/y86_dmem_responder.sv
// Slave end of the Y86 data-memory interface: one outstanding request,
// fixed access latency, range-checked access into a byte array.
module y86_dmem_responder
  import y86_dmem_responder_pkg::*;
#(
  parameter int DATA_WID  = DMEM_DATA_WID,
  parameter int ADDR_WID  = 64,
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_WID-1:0] req_addr,
  input  logic [DATA_WID-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_WID-1:0] rsp_rdata,
  output logic                rsp_error,
  output logic                busy
);

  localparam int NBYTES  = DATA_WID / 8;
  localparam int IDX_WID = $clog2(MEM_BYTES);

  localparam logic [ADDR_WID:0] LAST_OFS  = (ADDR_WID + 1)'(NBYTES - 1);
  localparam logic [ADDR_WID:0] MEM_LIMIT = (ADDR_WID + 1)'(MEM_BYTES);
  localparam logic [3:0]        CNT_LOAD  = latency_preload(LATENCY);

  state_t              state;
  logic [3:0]          cnt;
  logic                lat_write;
  logic [ADDR_WID-1:0] lat_addr;
  logic [DATA_WID-1:0] lat_wdata;

  logic [ADDR_WID:0]   end_addr;
  logic                addr_err;
  logic                access;
  logic                mem_we;
  logic [DATA_WID-1:0] mem_rdata;

  // One extra bit so an access wrapping past the top of the address space
  // is seen as out of range instead of aliasing onto low memory.
  assign end_addr = {1'b0, lat_addr} + LAST_OFS;
  assign addr_err = (end_addr >= MEM_LIMIT);
  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign mem_we   = access && lat_write && !addr_err;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  dmem_byte_array #(
    .DATA_WID  (DATA_WID),
    .MEM_BYTES (MEM_BYTES)
  ) u_bytes (
    .CLK   (CLK),
    .wr_en (mem_we),
    .base  (lat_addr[IDX_WID-1:0]),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Storage commit happens on this same edge through mem_we
          if (cnt == 4'd0) begin
            rsp_error <= addr_err;
            rsp_rdata <= (lat_write || addr_err) ? '0 : mem_rdata;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Directed plus randomized checks of the data-memory responder against a
// byte-array reference model; a second instance covers single-cycle latency.
module tb_y86_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_error, a_busy;
  logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_error, b_busy;
  logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_a [1024];
  logic [7:0] model_b [1024];

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  y86_dmem_responder #(.DATA_WID(64), .ADDR_WID(64), .MEM_BYTES(1024), .LATENCY(2)) dut_a (
    .CLK(clk), .RST(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_error(a_rsp_error), .busy(a_busy)
  );

  y86_dmem_responder #(.DATA_WID(64), .ADDR_WID(64), .MEM_BYTES(1024), .LATENCY(1)) dut_b (
    .CLK(clk), .RST(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_error(b_rsp_error), .busy(b_busy)
  );

  function automatic bit addrBad(input logic [63:0] addr);
    logic [64:0] last_byte;
    last_byte = {1'b0, addr} + 65'd7;
    return last_byte >= 65'd1024;
  endfunction

  // Applies one access to the chosen model and returns the expected read data
  function automatic logic [63:0] modelAccess(input bit use_b, input logic wr,
                                              input logic [63:0] addr, input logic [63:0] wd);
    logic [63:0] r;
    int idx;
    r = 64'd0;
    if (addrBad(addr)) return 64'd0;
    for (int i = 0; i < 8; i++) begin
      idx = int'(addr[9:0]) + i;
      if (wr) begin
        if (use_b) model_b[idx] = wd[8*i +: 8];
        else       model_a[idx] = wd[8*i +: 8];
      end else begin
        r[8*i +: 8] = use_b ? model_b[idx] : model_a[idx];
      end
    end
    return wr ? 64'd0 : r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Runs one access on instance A; entered and left just after a falling edge
  task automatic applyStimulus(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                               input int hold, output logic [63:0] rdata, output logic err);
    int lat;
    a_req_write = wr;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_req_valid = 1'b1;
    checkOutput("req_ready_idle", 64'(a_req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_after_accept", 64'(a_busy), 64'd1);
    a_req_addr  = {$urandom, $urandom};
    a_req_wdata = {$urandom, $urandom};
    a_req_write = ~wr;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      checkOutput("req_ready_wait", 64'(a_req_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    a_req_valid = 1'b0;
    checkOutput("rsp_latency", 64'(lat), 64'd2);
    rdata = a_rsp_rdata;
    err   = a_rsp_error;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkOutput("hold_rsp_valid", 64'(a_rsp_valid), 64'd1);
      checkOutput("hold_rdata", a_rsp_rdata, rdata);
      checkOutput("hold_error", 64'(a_rsp_error), 64'(err));
      checkOutput("hold_req_ready", 64'(a_req_ready), 64'd0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", 64'(a_rsp_valid), 64'd0);
    checkOutput("req_ready_after_hs", 64'(a_req_ready), 64'd1);
    checkOutput("rdata_cleared", a_rsp_rdata, 64'd0);
    checkOutput("busy_cleared", 64'(a_busy), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic wr, input logic [63:0] addr,
                       input logic [63:0] wd, input int hold);
    logic [63:0] got;
    logic        got_err;
    logic [63:0] exp_data;
    logic        exp_err;
    exp_err = addrBad(addr);
    applyStimulus(wr, addr, wd, hold, got, got_err);
    exp_data = modelAccess(1'b0, wr, addr, wd);
    checkOutput({tag, "_rdata"}, got, exp_data);
    checkOutput({tag, "_error"}, 64'(got_err), 64'(exp_err));
  endtask

  initial begin
    logic [63:0] got;
    logic        got_err;
    logic [63:0] b_addrs [6];
    int          last_acc;
    int          idx;
    int          n_rsp;
    rsp_t        e;

    a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 0;

    #2;
    checkOutput("reset_req_ready", 64'(a_req_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(a_rsp_valid), 64'd0);
    checkOutput("reset_rsp_rdata", a_rsp_rdata, 64'd0);
    checkOutput("reset_rsp_error", 64'(a_rsp_error), 64'd0);
    checkOutput("reset_busy", 64'(a_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] filling storage with known contents");
    for (int w = 0; w < 128; w++) begin
      runOp("init", 1'b1, 64'(w * 8), {$urandom, $urandom}, 0);
    end

    $display("[TB] reset during WAIT");
    a_req_write = 1'b1;
    a_req_addr  = 64'h10;
    a_req_wdata = 64'h1122334455667788;
    a_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(a_busy), 64'd0);
    checkOutput("midrst_req_ready", 64'(a_req_ready), 64'd1);
    checkOutput("midrst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 64'h10, 64'd0, 0, got, got_err);
    checkOutput("midrst_read_rdata", got, modelAccess(1'b0, 1'b0, 64'h10, 64'd0));
    checkOutput("midrst_read_error", 64'(got_err), 64'd0);

    $display("[TB] write then read");
    runOp("wr20", 1'b1, 64'h20, 64'h0123456789ABCDEF, 0);
    applyStimulus(1'b0, 64'h20, 64'd0, 0, got, got_err);
    checkOutput("rd20_rdata", got, 64'h0123456789ABCDEF);
    checkOutput("rd20_byte0", 64'(got[7:0]), 64'hEF);
    runOp("rd1d", 1'b0, 64'h1D, 64'd0, 0);

    $display("[TB] boundary and wrap-around");
    runOp("wr3f9", 1'b1, 64'h3F9, 64'hDEADBEEFCAFEF00D, 0);
    runOp("rd3f8", 1'b0, 64'h3F8, 64'd0, 0);
    runOp("rd3f9", 1'b0, 64'h3F9, 64'd0, 0);
    runOp("rdwrap", 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 0);
    runOp("wrwrap", 1'b1, 64'hFFFFFFFFFFFFFFF9, 64'h5555AAAA5555AAAA, 0);
    runOp("rd000", 1'b0, 64'h0, 64'd0, 0);

    $display("[TB] response backpressure");
    runOp("bp_read", 1'b0, 64'h123, 64'd0, 5);
    runOp("bp_write", 1'b1, 64'h3F8, {$urandom, $urandom}, 5);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      logic [63:0] addr;
      addr = ($urandom_range(0, 9) == 0) ? {32'hFFFFFFFF, $urandom} : 64'($urandom_range(0, 1030));
      runOp("rand", 1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("[TB] single-cycle latency back-to-back");
    last_acc = -1;
    idx = 0;
    n_rsp = 0;
    b_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      checkOutput("b_busy", 64'(b_busy), 64'(exp_q.size() != 0));
      if (b_rsp_valid) begin
        checkOutput("b_rsp_pending", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("b_rdata", b_rsp_rdata, e.rdata);
          checkOutput("b_error", 64'(b_rsp_error), 64'(e.err));
        end
        n_rsp++;
      end
      if (b_req_ready) begin
        if (idx < 13) begin
          if (last_acc >= 0) checkOutput("b_spacing", 64'(cyc - last_acc), 64'd3);
          if (idx < 6) begin
            b_addrs[idx] = 64'(idx * 32 + $urandom_range(0, 7));
            b_req_write  = 1'b1;
            b_req_addr   = b_addrs[idx];
            b_req_wdata  = {$urandom, $urandom};
          end else if (idx < 12) begin
            b_req_write  = 1'b0;
            b_req_addr   = b_addrs[idx - 6];
            b_req_wdata  = {$urandom, $urandom};
          end else begin
            b_req_write  = 1'b0;
            b_req_addr   = 64'h3FC;
          end
          e.err   = addrBad(b_req_addr);
          e.rdata = modelAccess(1'b1, b_req_write, b_req_addr, b_req_wdata);
          exp_q.push_back(e);
          b_req_valid = 1'b1;
          last_acc = cyc;
          idx++;
        end else begin
          b_req_valid = 1'b0;
        end
      end
    end
    checkOutput("b_issued", 64'(idx), 64'd13);
    checkOutput("b_responses", 64'(n_rsp), 64'd13);
    checkOutput("b_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
